tdm_demux_8: RTL and testbench

Receiving end of the 8-channel time-division link built around the 8:1 mux. The mux scans sel 0..7 and serialises channels a..h onto one line. This block takes that serial beat stream and rebuilds the 8 parallel channels. It holds them in a staging register and publishes a complete, coherent frame once per 8 beats. It also drives the slot index back to the transmitting mux's sel and flags framing errors.

---
 rtl/mux_pkg.sv | 31 +++
 rtl/tdm_slot_counter.sv | 35 +++
 rtl/tdm_demux_8.sv | 125 ++++++++++++
 tb/tb_tdm_demux_8.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared constants and types for the 8-channel TDM link (transmit mux and receive demux).
package mux_pkg;

    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;

    localparam logic [SEL_W-1:0] LAST_SLOT = 3'd7;

    // Receiver framing state: waiting for slot 0, or collecting slots 1..7.
    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_e;

    // Slot i lands in ch_out slice (7 - i), so channel a (slot 0) is the MSB slice.
    // Entry i of this table lives at bits [i*SEL_W +: SEL_W].
    localparam logic [NUM_CH*SEL_W-1:0] SLOT_TO_SLICE = {
        3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7
    };

    // Channel slice index for a given slot.
    function automatic logic [SEL_W-1:0] slot_to_slice(input logic [SEL_W-1:0] slot);
        return SLOT_TO_SLICE[int'(slot)*SEL_W +: SEL_W];
    endfunction

    // Bit offset of a slot's slice inside a packed NUM_CH*width frame.
    function automatic int slot_lsb(input logic [SEL_W-1:0] slot, input int width);
        return int'(slot_to_slice(slot)) * width;
    endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// 3-bit TDM slot counter: clear to 0, load to 1 (slot 0 just consumed), increment,
// and a flag when the counter sits on the last slot.
module tdm_slot_counter
    import mux_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_load1,
    input  logic             i_en,
    output logic [SEL_W-1:0] o_count,
    output logic             o_last
);

    logic [SEL_W-1:0] r_count;

    // Slot register; clear has priority over load, load over increment.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= 3'd0;
        end else if (i_clr) begin
            r_count <= 3'd0;
        end else if (i_load1) begin
            r_count <= 3'd1;
        end else if (i_en) begin
            r_count <= r_count + 3'd1;
        end else begin
            r_count <= r_count;
        end
    end

    assign o_count = r_count;
    assign o_last  = (r_count == LAST_SLOT);

endmodule

// File: rtl/tdm_demux_8.sv
// Receive side of the 8-channel TDM link: rebuilds the parallel channels from the
// serial beat stream, publishes one coherent frame per 8 beats and flags framing errors.
module tdm_demux_8
    import mux_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [WIDTH-1:0]        din,
    input  logic                    din_valid,
    input  logic                    frame_start,
    output logic [SEL_W-1:0]        sel_out,
    output logic [NUM_CH*WIDTH-1:0] ch_out,
    output logic                    frame_valid,
    output logic                    sync_err
);

    localparam int FRAME_W = NUM_CH * WIDTH;

    state_e             r_state;
    state_e             w_state_nxt;
    logic [FRAME_W-1:0] r_stage;
    logic [FRAME_W-1:0] w_stage_nxt;
    logic [FRAME_W-1:0] r_ch;
    logic [FRAME_W-1:0] w_ch_nxt;
    logic               r_frame_valid;
    logic               w_frame_valid_nxt;
    logic               r_sync_err;
    logic               w_sync_err_nxt;

    logic               w_cnt_clr;
    logic               w_cnt_load1;
    logic               w_cnt_en;
    logic [SEL_W-1:0]   w_slot;
    logic               w_slot_last;

    tdm_slot_counter u_slot_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (w_cnt_clr),
        .i_load1 (w_cnt_load1),
        .i_en    (w_cnt_en),
        .o_count (w_slot),
        .o_last  (w_slot_last)
    );

    // State, staging, published frame and status pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_stage       <= '0;
            r_ch          <= '0;
            r_frame_valid <= 1'b0;
            r_sync_err    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_stage       <= w_stage_nxt;
            r_ch          <= w_ch_nxt;
            r_frame_valid <= w_frame_valid_nxt;
            r_sync_err    <= w_sync_err_nxt;
        end
    end

    // Framing decisions for the beat presented this cycle.
    always_comb begin
        w_state_nxt       = r_state;
        w_stage_nxt       = r_stage;
        w_ch_nxt          = r_ch;
        w_frame_valid_nxt = 1'b0;
        w_sync_err_nxt    = 1'b0;
        w_cnt_clr         = 1'b0;
        w_cnt_load1       = 1'b0;
        w_cnt_en          = 1'b0;

        case (r_state)
            IDLE: begin
                if (din_valid && frame_start) begin
                    // Fresh frame: start from an empty staging register.
                    w_stage_nxt = '0;
                    w_stage_nxt[slot_lsb(3'd0, WIDTH) +: WIDTH] = din;
                    w_cnt_load1 = 1'b1;
                    w_state_nxt = COLLECT;
                end else if (din_valid) begin
                    // Beat with no frame context is dropped.
                    w_sync_err_nxt = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            COLLECT: begin
                if (din_valid && frame_start) begin
                    // Early restart: partial frame discarded, this beat is the new slot 0.
                    w_sync_err_nxt = 1'b1;
                    w_stage_nxt    = '0;
                    w_stage_nxt[slot_lsb(3'd0, WIDTH) +: WIDTH] = din;
                    w_cnt_load1    = 1'b1;
                end else if (din_valid) begin
                    w_stage_nxt[slot_lsb(w_slot, WIDTH) +: WIDTH] = din;
                    if (w_slot_last) begin
                        // Slot-7 beat merged straight into the published frame.
                        w_ch_nxt          = w_stage_nxt;
                        w_frame_valid_nxt = 1'b1;
                        w_cnt_clr         = 1'b1;
                        w_state_nxt       = IDLE;
                    end else begin
                        w_cnt_en = 1'b1;
                    end
                end else begin
                    w_state_nxt = COLLECT;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_clr   = 1'b1;
            end
        endcase
    end

    assign sel_out     = w_slot;
    assign ch_out      = r_ch;
    assign frame_valid = r_frame_valid;
    assign sync_err    = r_sync_err;

endmodule

// File: tb/tb_tdm_demux_8.sv
// Self-checking bench for tdm_demux_8: directed frames from the test plan, then
// randomized traffic, all checked every cycle against a queue-based frame model.
module tb_tdm_demux_8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [0:0] din;
    logic       din_valid;
    logic       frame_start;
    logic [2:0] sel_out;
    logic [7:0] ch_out;
    logic       frame_valid;
    logic       sync_err;

    always #5 clk = ~clk;

    tdm_demux_8 #(.WIDTH(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .din_valid   (din_valid),
        .frame_start (frame_start),
        .sel_out     (sel_out),
        .ch_out      (ch_out),
        .frame_valid (frame_valid),
        .sync_err    (sync_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model: beats of the frame in progress, last published frame, pulses, next slot.
    logic       m_cur[$];
    logic [7:0] m_ch  = 8'h00;
    logic       m_fv  = 1'b0;
    logic       m_err = 1'b0;
    int         m_sel = 0;
    bit         check_en = 1'b0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Apply one clock edge's worth of link rules to the model.
    task automatic model_update(input logic r, input logic v, input logic fs, input logic d);
        m_fv  = 1'b0;
        m_err = 1'b0;
        if (!r) begin
            m_cur.delete();
            m_ch = 8'h00;
        end else if (v) begin
            if (fs) begin
                if (m_cur.size() != 0) m_err = 1'b1;
                m_cur.delete();
                m_cur.push_back(d);
            end else if (m_cur.size() == 0) begin
                m_err = 1'b1;
            end else begin
                m_cur.push_back(d);
                if (m_cur.size() == 8) begin
                    for (int i = 0; i < 8; i++) m_ch[7-i] = m_cur[i];
                    m_fv = 1'b1;
                    m_cur.delete();
                end
            end
        end
        m_sel = m_cur.size();
    endtask

    task automatic step(input logic r, input logic v, input logic fs, input logic d);
        @(negedge clk);
        rst_n       = r;
        din_valid   = v;
        frame_start = fs;
        din         = d;
        @(posedge clk);
        model_update(r, v, fs, d);
    endtask

    task automatic send_frame(input logic [7:0] bits);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, (i == 0), bits[7-i]);
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (check_en) begin
            chk("ch_out",      ch_out,              m_ch);
            chk("sel_out",     {5'd0, sel_out},     m_sel[7:0]);
            chk("frame_valid", {7'd0, frame_valid}, {7'd0, m_fv});
            chk("sync_err",    {7'd0, sync_err},    {7'd0, m_err});
        end
    end

    initial begin
        logic r, v, fs, d;
        rst_n = 1'b0; din = 1'b0; din_valid = 1'b0; frame_start = 1'b0;

        step(1'b0, 1'b0, 1'b0, 1'b0);
        check_en = 1'b1;
        step(1'b0, 1'b1, 1'b1, 1'b1);
        #1;
        chk("lit_reset_ch", ch_out, 8'h00);
        chk("lit_reset_sel", {5'd0, sel_out}, 8'h00);

        // Frame 1 then back-to-back frame 2.
        send_frame(8'b10101010);
        #1;
        chk("lit_f1_ch", ch_out, 8'hAA);
        chk("lit_f1_model", m_ch, 8'hAA);
        chk("lit_f1_fv", {7'd0, frame_valid}, 8'h01);
        send_frame(8'b11001100);
        #1;
        chk("lit_f2_ch", ch_out, 8'hCC);
        chk("lit_f2_fv", {7'd0, frame_valid}, 8'h01);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        chk("lit_f2_fv_drop", {7'd0, frame_valid}, 8'h00);

        // Frame with a 3-cycle gap between slots 3 and 4.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, (i == 0), (i % 2 == 0));
            if (i == 3) begin
                for (int g = 0; g < 3; g++) step(1'b1, 1'b0, 1'b0, 1'b1);
                #1;
                chk("lit_gap_sel", {5'd0, sel_out}, 8'h04);
            end
        end
        #1;
        chk("lit_gap_ch", ch_out, 8'hAA);

        // Early restart at slot 5.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, (i == 0), 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        #1;
        chk("lit_restart_err", {7'd0, sync_err}, 8'h01);
        chk("lit_restart_ch", ch_out, 8'hAA);
        chk("lit_restart_sel", {5'd0, sel_out}, 8'h01);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
        #1;
        chk("lit_restart_frame", ch_out, 8'hBF);
        chk("lit_restart_model", m_ch, 8'hBF);

        // Stray beat while idle.
        step(1'b1, 1'b1, 1'b0, 1'b1);
        #1;
        chk("lit_stray_err", {7'd0, sync_err}, 8'h01);
        chk("lit_stray_sel", {5'd0, sel_out}, 8'h00);
        chk("lit_stray_ch", ch_out, 8'hBF);

        // Reset at slot 4, then a clean frame.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, (i == 0), 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        #1;
        chk("lit_midrst_ch", ch_out, 8'h00);
        chk("lit_midrst_sel", {5'd0, sel_out}, 8'h00);
        send_frame(8'b01010101);
        #1;
        chk("lit_postrst_ch", ch_out, 8'h55);

        // Randomized traffic with occasional errors and resets.
        for (int n = 0; n < 3000; n++) begin
            r  = ($urandom_range(0, 499) != 0);
            v  = ($urandom_range(0, 9) < 7);
            fs = (m_cur.size() == 0) ? ($urandom_range(0, 19) != 0)
                                     : ($urandom_range(0, 39) == 0);
            d  = $urandom_range(0, 1);
            step(r, v, fs, d);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
